flag_ccr_unit: RTL and testbench
================================

Name: flag_ccr_unit

Overview:
- Condition-code register (CCR) that captures the {N,C,Z} flags produced by the execute-stage ALU.
- Resolves conditional branches (JZ/JN/JC/JMP) from those flags and clears the tested flag on a taken conditional branch.
- Holds a small shadow stack that saves flags on interrupt entry and restores them on RTI.
- Sits between EX and the fetch/PC-select logic.

Parameters:
- SHADOW_DEPTH, 2, number of flag snapshots the interrupt shadow stack holds (1..4).
- PTR_W, 3, width of the stack depth counter; must satisfy 2^PTR_W > SHADOW_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_flag  in  3  ALU flags {N,C,Z}; bit2=N, bit1=C, bit0=Z.
- flag_we  in  3  per-bit write enable for alu_flag, same bit order.
- setc  in  1  SETC instruction: C<=1.
- clrc  in  1  CLRC instruction: C<=0.
- br_valid  in  1  branch instruction present this cycle.
- br_type  in  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- int_save  in  1  interrupt entry: push flags.
- rti_restore  in  1  RTI: pop flags.
- stall  in  1  pipeline hold; freezes all state.
- flags  out  3  registered CCR {N,C,Z}.
- branch_taken  out  1  branch resolution, combinational.
- stk_depth  out  PTR_W  current number of shadow entries.
- stk_err  out  1  registered one-cycle pulse on illegal stack operation.

Behaviour:
- Reset: sampled only on a rising clk with rst_n=0. It sets flags=000, stk_depth=0, stk_err=0, and clears all shadow entries. While rst_n=0, branch_taken is forced to 0. Reset overrides stall.
- stall=1: flags, stack and stk_err are held. branch_taken is forced to 0.
- Effective flags eff[2:0]:
  - With bypass: per bit, flag_we[i] ? alu_flag[i] : flags[i], then setc/clrc applied to the C bit.
  - Without bypass: eff = flags.
- branch_taken = br_valid & (JMP | (JZ & eff[0]) | (JN & eff[2]) | (JC & eff[1])).
- Next-state priority for flags, highest first:
  1. rti_restore with non-empty stack → flags <= top entry; the whole CCR is replaced.
  2. Otherwise, build the write value in three ordered steps:
     - per-bit ALU write;
     - setc/clrc on C (setc&clrc together → C unchanged, stk_err not affected);
     - clear-on-taken: a taken JZ/JN/JC clears the tested bit (Z/N/C) in the next cycle. A taken JMP clears nothing.
- Latency: a flag update is visible on `flags` one cycle after its write. branch_taken uses the same-cycle view (eff).
- Shadow stack (LIFO):
  - int_save pushes eff and increments stk_depth.
  - rti_restore pops and decrements stk_depth.
  - Push when stk_depth==SHADOW_DEPTH: dropped, stk_err=1 next cycle.
  - Pop when stk_depth==0: flags follow rule 2, stk_err=1 next cycle.
  - int_save & rti_restore in the same cycle: restore performed, save dropped, stk_err=1.
  - Depth never wraps; it saturates at 0 and SHADOW_DEPTH.
- stk_err is 0 in every cycle without an error event.
- Reset asserted mid-operation discards any pending save, restore or clear-on-taken.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: eff forwards the same-cycle alu_flag/flag_we and setc/clrc into branch evaluation and into int_save pushes, so a branch directly after a flag-setting instruction resolves with zero bubbles.
- Undefined: eff = flags (registered only). The hazard unit must insert one bubble between a flag write and a dependent branch, and the bench must account for one-cycle-stale flags.

Decomposition:
- Shared package `ccr_pkg`:
  - flag index constants FLAG_N=2, FLAG_C=1, FLAG_Z=0;
  - branch-type encodings BR_JZ/BR_JN/BR_JC/BR_JMP;
  - typedef flags_t (3-bit).
- One sub-module: `flag_shadow_stack`. Parameterised LIFO with push/pop/full/empty/depth/top. It owns the pointer and error detection; the top level owns flag priority and branch logic.

Test Plan:
- Reset then ALU write: rst_n=0 for 2 cycles, release, alu_flag=101, flag_we=111 → flags=101 next cycle; stk_depth=0.
- Taken JZ clears Z: flags=001, br_valid=1, br_type=00 → branch_taken=1; flags=000 next cycle. JZ with flags=000 → branch_taken=0, flags unchanged.
- Bypass: alu_flag=100, flag_we=111, br_valid=1, br_type=01 in the same cycle.
  - FLAG_BYPASS_EN defined → branch_taken=1, flags=000 next cycle.
  - Undefined → branch_taken=0.
- Shadow stack round trip (SHADOW_DEPTH=2):
  - flags=110, int_save → stk_depth=1;
  - write 001, then rti_restore → flags=110, stk_depth=0.
- Stack errors:
  - 3 consecutive int_save → depth saturates at 2, stk_err=1 on the cycle after the third save.
  - rti_restore at depth 0 → stk_err=1, flags unchanged.
- Stall and priority:
  - stall=1 with flag_we=111 → flags held and branch_taken=0.
  - setc=1 & clrc=1 → C unchanged.
  - int_save & rti_restore together at depth 1 → restore applied, depth 0, stk_err=1.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared definitions for the condition-code register unit: flag bit positions,
// branch-type encodings and the flag vector type.
package ccr_pkg;

    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    localparam logic [1:0] BR_JZ  = 2'b00;
    localparam logic [1:0] BR_JN  = 2'b01;
    localparam logic [1:0] BR_JC  = 2'b10;
    localparam logic [1:0] BR_JMP = 2'b11;

    typedef logic [2:0] flags_t;

endpackage

// File: rtl/flag_ccr_unit_if.sv
// Bus between the execute stage / PC-select logic and the CCR unit.
// The master side drives flag writes, branch and interrupt requests; the slave is the CCR.
interface flag_ccr_unit_if #(
    parameter int PTR_W = 3
);
    import ccr_pkg::*;

    flags_t             alu_flag;
    flags_t             flag_we;
    logic               setc;
    logic               clrc;
    logic               br_valid;
    logic [1:0]         br_type;
    logic               int_save;
    logic               rti_restore;
    logic               stall;
    flags_t             flags;
    logic               branch_taken;
    logic [PTR_W-1:0]   stk_depth;
    logic               stk_err;

    modport master (
        output alu_flag, flag_we, setc, clrc, br_valid, br_type,
               int_save, rti_restore, stall,
        input  flags, branch_taken, stk_depth, stk_err
    );

    modport slave (
        input  alu_flag, flag_we, setc, clrc, br_valid, br_type,
               int_save, rti_restore, stall,
        output flags, branch_taken, stk_depth, stk_err
    );

endinterface

// File: rtl/flag_shadow_stack.sv
// LIFO of flag snapshots used across interrupt entry/return. Owns the depth
// pointer and flags illegal operations with a registered one-cycle error pulse.
module flag_shadow_stack
    import ccr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  flags_t           push_data,
    output flags_t           top,
    output logic [PTR_W-1:0] depth,
    output logic             empty,
    output logic             err
);

    flags_t           mem [DEPTH];
    logic [PTR_W-1:0] depth_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic             err_evt;
    logic             err_q;

    // A simultaneous push and pop keeps the pop and drops the push as an error.
    always_comb begin
        full    = (depth_q == PTR_W'(DEPTH));
        empty   = (depth_q == '0);
        pop_ok  = pop & ~empty;
        push_ok = push & ~pop & ~full;
        err_evt = (push & pop) | (push & full) | (pop & empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            err_q <= err_evt;
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++)
                    if (depth_q == PTR_W'(i)) mem[i] <= push_data;
                depth_q <= depth_q + 1'b1;
            end else if (pop_ok) begin
                depth_q <= depth_q - 1'b1;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (depth_q == PTR_W'(i + 1)) top = mem[i];
    end

    assign depth = depth_q;
    assign err   = err_q;

endmodule

// File: rtl/flag_ccr_unit.sv
// Condition-code register with branch resolution, clear-on-taken and interrupt shadow stack.
// Define FLAG_BYPASS_EN to forward same-cycle flag writes into branch evaluation and saves.
module flag_ccr_unit
    import ccr_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int PTR_W        = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    flag_ccr_unit_if.slave bus
);

    flags_t flags_q;
    flags_t write_val;
    flags_t eff;
    flags_t cleared;
    flags_t next_flags;
    flags_t stk_top;
    logic   stk_empty;
    logic   cond;
    logic   bt_raw;
    logic   restore_ok;

    // setc together with clrc cancels out and leaves C alone.
    always_comb begin
        write_val = (bus.flag_we & bus.alu_flag) | (~bus.flag_we & flags_q);
        if (bus.setc && !bus.clrc)
            write_val[FLAG_C] = 1'b1;
        else if (bus.clrc && !bus.setc)
            write_val[FLAG_C] = 1'b0;
`ifdef FLAG_BYPASS_EN
        eff = write_val;
`else
        eff = flags_q;
`endif
    end

    always_comb begin
        cond = 1'b0;
        case (bus.br_type)
            BR_JZ:   cond = eff[FLAG_Z];
            BR_JN:   cond = eff[FLAG_N];
            BR_JC:   cond = eff[FLAG_C];
            default: cond = 1'b1;
        endcase
        bt_raw = bus.br_valid & cond;
    end

    // A taken conditional branch consumes the flag it tested; a restore overrides everything.
    always_comb begin
        cleared = write_val;
        if (bt_raw) begin
            case (bus.br_type)
                BR_JZ:   cleared[FLAG_Z] = 1'b0;
                BR_JN:   cleared[FLAG_N] = 1'b0;
                BR_JC:   cleared[FLAG_C] = 1'b0;
                default: cleared = write_val;
            endcase
        end
        restore_ok = bus.rti_restore & ~stk_empty;
        next_flags = restore_ok ? stk_top : cleared;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            flags_q <= '0;
        else if (!bus.stall)
            flags_q <= next_flags;
    end

    flag_shadow_stack #(
        .DEPTH (SHADOW_DEPTH),
        .PTR_W (PTR_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (~bus.stall),
        .push      (bus.int_save),
        .pop       (bus.rti_restore),
        .push_data (eff),
        .top       (stk_top),
        .depth     (bus.stk_depth),
        .empty     (stk_empty),
        .err       (bus.stk_err)
    );

    assign bus.flags        = flags_q;
    assign bus.branch_taken = rst_n & ~bus.stall & bt_raw;

endmodule

// File: tb/tb_flag_ccr_unit.sv
// Directed scoreboard bench for flag_ccr_unit (SHADOW_DEPTH=2); expectations follow
// FLAG_BYPASS_EN when it is defined for the build.
module tb_flag_ccr_unit;

    typedef struct {
        string      tag;
        logic [2:0] flags;
        logic [2:0] depth;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];

    flag_ccr_unit_if #(.PTR_W(3)) bus ();

    flag_ccr_unit #(
        .SHADOW_DEPTH (2),
        .PTR_W        (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: check the combinational branch result mid-cycle,
    // queue the registered expectations, then pop and compare after the edge.
    task automatic apply_stimulus(
        input string      tag,
        input logic       rn,
        input logic [2:0] af, we,
        input logic       sc, cc, bv,
        input logic [1:0] bty,
        input logic       sv, rs, st,
        input logic       exp_bt,
        input logic [2:0] exp_flags,
        input logic [2:0] exp_depth,
        input logic       exp_err
    );
        exp_t e;
        rst_n           = rn;
        bus.alu_flag    = af;
        bus.flag_we     = we;
        bus.setc        = sc;
        bus.clrc        = cc;
        bus.br_valid    = bv;
        bus.br_type     = bty;
        bus.int_save    = sv;
        bus.rti_restore = rs;
        bus.stall       = st;
        #2;
        checks++;
        assert (bus.branch_taken === exp_bt) else begin
            failures++;
            $error("[TB] FAIL %s.branch_taken observed=%b expected=%b", tag, bus.branch_taken, exp_bt);
        end
        e.tag = tag; e.flags = exp_flags; e.depth = exp_depth; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (bus.flags === e.flags) else begin
            failures++;
            $error("[TB] FAIL %s.flags observed=%b expected=%b", e.tag, bus.flags, e.flags);
        end
        checks++;
        assert (bus.stk_depth === e.depth) else begin
            failures++;
            $error("[TB] FAIL %s.stk_depth observed=%0d expected=%0d", e.tag, bus.stk_depth, e.depth);
        end
        checks++;
        assert (bus.stk_err === e.err) else begin
            failures++;
            $error("[TB] FAIL %s.stk_err observed=%b expected=%b", e.tag, bus.stk_err, e.err);
        end
    endtask

    initial begin
        logic       byp_bt;
        logic [2:0] byp_flags;
`ifdef FLAG_BYPASS_EN
        byp_bt = 1'b1; byp_flags = 3'b000;
`else
        byp_bt = 1'b0; byp_flags = 3'b100;
`endif
        rst_n = 1'b0;
        bus.alu_flag = '0; bus.flag_we = '0; bus.setc = 0; bus.clrc = 0;
        bus.br_valid = 0; bus.br_type = '0; bus.int_save = 0; bus.rti_restore = 0; bus.stall = 0;
        @(posedge clk);
        #1;
        //              tag          rn af     we     sc cc bv ty     sv rs st  bt    flags   d     err
        apply_stimulus("reset1",     0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 3'd0, 0);
        apply_stimulus("reset2",     0, 3'b111, 3'b111, 0, 0, 1, 2'b11, 1, 0, 0, 0, 3'b000, 3'd0, 0);
        apply_stimulus("alu_wr101",  1, 3'b101, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b101, 3'd0, 0);
        apply_stimulus("alu_wr001",  1, 3'b001, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 3'd0, 0);
        apply_stimulus("jz_taken",   1, 3'b000, 3'b000, 0, 0, 1, 2'b00, 0, 0, 0, 1, 3'b000, 3'd0, 0);
        apply_stimulus("jz_not",     1, 3'b000, 3'b000, 0, 0, 1, 2'b00, 0, 0, 0, 0, 3'b000, 3'd0, 0);
        apply_stimulus("bypass_jn",  1, 3'b100, 3'b111, 0, 0, 1, 2'b01, 0, 0, 0, byp_bt, byp_flags, 3'd0, 0);
        apply_stimulus("alu_wr110",  1, 3'b110, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("save1",      1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b110, 3'd1, 0);
        apply_stimulus("alu_wr001b", 1, 3'b001, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b001, 3'd1, 0);
        apply_stimulus("rti1",       1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("rti_empty",  1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 3'b110, 3'd0, 1);
        apply_stimulus("err_clear",  1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("push_a",     1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b110, 3'd1, 0);
        apply_stimulus("alu_wr011",  1, 3'b011, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b011, 3'd1, 0);
        apply_stimulus("push_b",     1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b011, 3'd2, 0);
        apply_stimulus("push_full",  1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b011, 3'd2, 1);
        apply_stimulus("full_idle",  1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b011, 3'd2, 0);
        apply_stimulus("pop_b",      1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 3'b011, 3'd1, 0);
        apply_stimulus("pop_a",      1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("rti_empty2", 1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 3'b110, 3'd0, 1);
        apply_stimulus("stall_hold", 1, 3'b001, 3'b111, 1, 0, 1, 2'b11, 1, 0, 1, 0, 3'b110, 3'd0, 1);
        apply_stimulus("post_stall", 1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("setc_clrc",  1, 3'b000, 3'b000, 1, 1, 0, 2'b00, 0, 0, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("clrc",       1, 3'b000, 3'b000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 3'b100, 3'd0, 0);
        apply_stimulus("setc",       1, 3'b000, 3'b000, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("jc_taken",   1, 3'b000, 3'b000, 0, 0, 1, 2'b10, 0, 0, 0, 1, 3'b100, 3'd0, 0);
        apply_stimulus("jn_taken",   1, 3'b000, 3'b000, 0, 0, 1, 2'b01, 0, 0, 0, 1, 3'b000, 3'd0, 0);
        apply_stimulus("jmp_taken",  1, 3'b000, 3'b000, 0, 0, 1, 2'b11, 0, 0, 0, 1, 3'b000, 3'd0, 0);
        apply_stimulus("jc_not",     1, 3'b000, 3'b000, 0, 0, 1, 2'b10, 0, 0, 0, 0, 3'b000, 3'd0, 0);
        apply_stimulus("alu_wr101b", 1, 3'b101, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b101, 3'd0, 0);
        apply_stimulus("save_d1",    1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b101, 3'd1, 0);
        apply_stimulus("alu_wr010",  1, 3'b010, 3'b111, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b010, 3'd1, 0);
        apply_stimulus("save_and_rti",1,3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 1, 0, 0, 3'b101, 3'd0, 1);
        apply_stimulus("err_clear2", 1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b101, 3'd0, 0);
        apply_stimulus("partial_we", 1, 3'b010, 3'b011, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b110, 3'd0, 0);
        apply_stimulus("save_mid",   1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b110, 3'd1, 0);
        apply_stimulus("reset_mid",  0, 3'b111, 3'b111, 0, 0, 1, 2'b11, 0, 1, 0, 0, 3'b000, 3'd0, 0);
        apply_stimulus("after_rst",  1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 3'b000, 3'd0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
